serial_adder: RTL and testbench

Bit-serial ripple adder. The complementary arithmetic block to the team's gate-level full subtractor.
- One full-adder cell plus a carry flip-flop processes one bit per clock, LSB first.
- Operands are loaded in parallel and the result is presented in parallel.
- Trades latency for area in datapaths that do not need a full-width combinational adder.

---
 rtl/serial_adder_if.sv | 42 ++++
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; the adder takes the slave side.
// With SERIAL_ADDER_SUB_EN defined the bundle also carries the subtract request.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, WIDTH clocks per operation.
// Optional build macro SERIAL_ADDER_SUB_EN adds a subtract mode (a - b via ~b and carry-in of 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_if.slave    io_bus
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-2:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_s;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_sumFull;
  logic [WIDTH-1:0] w_bLoad;
  logic             w_carryLoad;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_bLoad     = io_bus.sub ? ~io_bus.b : io_bus.b;
  assign w_carryLoad = io_bus.sub ? 1'b1 : io_bus.cin;
`else
  assign w_bLoad     = io_bus.b;
  assign w_carryLoad = io_bus.cin;
`endif

  // The accumulator holds only WIDTH-1 bits; the last sum bit is folded in directly from the cell.
  assign w_s         = r_aSh[0] ^ r_bSh[0] ^ r_carry;
  assign w_carryNext = (r_aSh[0] & r_bSh[0]) | (r_aSh[0] & r_carry) | (r_bSh[0] & r_carry);
  assign w_sumFull   = {w_s, r_acc};

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_load      = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_count == LAST_BIT) begin
          w_finish    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_aSh   <= io_bus.a;
        r_bSh   <= w_bLoad;
        r_carry <= w_carryLoad;
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_step) begin
        r_aSh   <= r_aSh >> 1;
        r_bSh   <= r_bSh >> 1;
        r_carry <= w_carryNext;
        r_acc   <= w_sumFull[WIDTH-1:1];
        r_count <= r_count + CW'(1);
        // On the MSB step r_carry is still the carry into the MSB, which is what overflow needs.
        if (w_finish) begin
          r_sum  <= w_sumFull;
          r_cout <= w_carryNext;
          r_ovf  <= r_carry ^ w_carryNext;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign io_bus.busy = (r_state == RUN);
  assign io_bus.done = r_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
  assign io_bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8, one task per scenario.
// Define SERIAL_ADDER_SUB_EN for both bench and RTL to exercise the subtract mode.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge; returns at the negedge after that edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; a timeout returns a cycle count no check will accept.
  task automatic waitDone(output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      if (bus.busy === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_basic();
    int cyc;
    int bc;
    applyStimulus(8'h0F, 8'h01, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %b expected 1", bus.busy); end
    waitDone(cyc, bc);
    checks++; if (cyc != 8) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 8", cyc); end
    checks++; if (bc != 8) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++; if (bus.sum !== 8'h10) begin errors++; $display("[TB] FAIL basic_sum: got %h expected 10", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL basic_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", bus.ovf); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); end
    checks++; if (bus.sum !== 8'h10) begin errors++; $display("[TB] FAIL basic_sum_hold: got %h expected 10", bus.sum); end
  endtask

  task automatic test_carry();
    int cyc;
    int bc;
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(cyc, bc);
    checks++; if (cyc != 8) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("[TB] FAIL wrap_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("[TB] FAIL wrap_cout: got %b expected 1", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf: got %b expected 0", bus.ovf); end
    applyStimulus(8'h7F, 8'h00, 1'b1);
    waitDone(cyc, bc);
    checks++; if (bus.sum !== 8'h80) begin errors++; $display("[TB] FAIL ovf_sum: got %h expected 80", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_ovf: got %b expected 1", bus.ovf); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bc;
    applyStimulus(8'h03, 8'h04, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cyc, bc);
    checks++; if (bus.sum !== 8'h07) begin errors++; $display("[TB] FAIL b2b_ignore_sum: got %h expected 07", bus.sum); end
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_clear: got %b expected 0", bus.done); end
    waitDone(cyc, bc);
    checks++; if (cyc != 8) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h30) begin errors++; $display("[TB] FAIL b2b_sum: got %h expected 30", bus.sum); end
  endtask

  task automatic test_abort();
    int cyc;
    int bc;
    int seen;
    applyStimulus(8'h55, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("[TB] FAIL abort_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: got cout=%b ovf=%b expected 0 0", bus.cout, bus.ovf); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", seen); end
    applyStimulus(8'h01, 8'h02, 1'b0);
    waitDone(cyc, bc);
    checks++; if (cyc != 8) begin errors++; $display("[TB] FAIL abort_fresh_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h03) begin errors++; $display("[TB] FAIL abort_fresh_sum: got %h expected 03", bus.sum); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int cyc;
    int bc;
    bus.sub = 1'b1;
    applyStimulus(8'h05, 8'h07, 1'b0);
    waitDone(cyc, bc);
    checks++; if (cyc != 8) begin errors++; $display("[TB] FAIL sub_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'hFE) begin errors++; $display("[TB] FAIL sub_neg_sum: got %h expected FE", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL sub_neg_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL sub_neg_ovf: got %b expected 0", bus.ovf); end
    applyStimulus(8'h80, 8'h01, 1'b0);
    waitDone(cyc, bc);
    checks++; if (bus.sum !== 8'h7F) begin errors++; $display("[TB] FAIL sub_ovf_sum: got %h expected 7F", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("[TB] FAIL sub_ovf_cout: got %b expected 1", bus.cout); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("[TB] FAIL sub_ovf_ovf: got %b expected 1", bus.ovf); end
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
